// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one 16-bit LFSR random source.
// Warm-up after reset/seed, ADV decorrelation shifts between grants.
module prng_arbiter #(
  parameter int NREQ = 4,
  parameter int ADV  = 8,
  parameter int WARM = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd,
  output logic            rnd_valid,
  output logic            busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (WARM > ADV) ? WARM : ADV;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [15:0] LFSR_RST = 16'hACE1;

  typedef enum logic [1:0] {
    WARMUP,
    READY,
    ADVANCE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rnd_q, rnd_d;
  logic            vld_q, vld_d;

  logic [15:0]     lfsr_sh;
  logic [7:0]      wht;
  logic [PW-1:0]   win;

  assign lfsr_sh = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  assign wht = {lfsr_q[14:8], lfsr_q[15]} ^ {lfsr_q[0], lfsr_q[7:1]};

  // Scan downward so the lowest offset from rr_q wins last.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_q) + i) % NREQ]) begin
        win = PW'((int'(rr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    vld_d   = 1'b0;
    if (seed_load) begin
      lfsr_d  = (seed == 16'h0000) ? LFSR_RST : seed;
      cnt_d   = CW'(WARM);
      state_d = WARMUP;
    end else begin
      unique case (state_q)
        WARMUP, ADVANCE: begin
          lfsr_d = lfsr_sh;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = READY;
        end
        READY: begin
          if (|req) begin
            gnt_d[win] = 1'b1;
            rnd_d      = wht;
            vld_d      = 1'b1;
            rr_d       = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            cnt_d      = CW'(ADV);
            state_d    = ADVANCE;
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARMUP;
      lfsr_q  <= LFSR_RST;
      cnt_q   <= CW'(WARM);
      rr_q    <= '0;
      gnt_q   <= '0;
      rnd_q   <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign rnd_valid = vld_q;
  assign busy      = (state_q != READY);

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter with a grant/rnd scoreboard.
// Expected grants are queued at drive time and popped on rnd_valid.
module tb_prng_arbiter;

  localparam int ADV  = 8;
  localparam int WARM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [7:0]  rnd;
  logic        rnd_valid;
  logic        busy;

  typedef struct {
    logic [3:0] g;
    logic [7:0] r;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ml;
  logic [7:0]  last_rnd = 8'h00;
  int          n;

  prng_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l, input int k);
    logic [15:0] x;
    x = l;
    for (int i = 0; i < k; i++) x = {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    return x;
  endfunction

  function automatic logic [7:0] whit(input logic [15:0] l);
    return {l[14:8], l[15]} ^ {l[0], l[7:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one expected grant; the model LFSR then advances ADV shifts.
  task automatic exp_push(input logic [3:0] g);
    exp_t e;
    e.g = g;
    e.r = whit(ml);
    sb.push_back(e);
    last_rnd = e.r;
    ml = step(ml, ADV);
  endtask

  task automatic wait_gnt(input int max, output int cnt);
    cnt = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      cnt++;
      if (rnd_valid) break;
    end
    chk("gnt_seen", rnd_valid, 1);
  endtask

  task automatic wait_ready(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("ready", busy, 0);
  endtask

  task automatic busy_window();
    for (int i = 0; i < WARM; i++) begin
      chk("busy_on", busy, 1);
      @(negedge clk);
    end
    chk("busy_off", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rnd_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", gnt, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_gnt", gnt, e.g);
          chk("sb_rnd", rnd, e.r);
        end
      end else begin
        chk("gnt_idle", gnt, 0);
      end
    end
  end

  initial begin
    logic [3:0] pats [2];
    pats[0] = 4'b0011;
    pats[1] = 4'b0101;
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0; req = 4'h0;

    // Reset and warm-up
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_rnd", rnd, 0);
    chk("rst_vld", rnd_valid, 0);
    ml = step(16'hACE1, WARM);
    busy_window();

    // Single requester, back-to-back grants
    req = 4'b0100;
    repeat (3) exp_push(4'b0100);
    wait_gnt(4, n);  chk("lat", n, 1);
    wait_gnt(20, n); chk("gap1", n, ADV + 1);
    wait_gnt(20, n); chk("gap2", n, ADV + 1);
    req = 4'b0000;
    wait_ready(20);

    // Round robin from rr_ptr=3
    req = 4'b1111;
    exp_push(4'b1000); exp_push(4'b0001); exp_push(4'b0010);
    exp_push(4'b0100); exp_push(4'b1000);
    wait_gnt(4, n); chk("rr_lat", n, 1);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(20, n); chk("rr_gap", n, ADV + 1);
    end
    req = 4'b1010;
    exp_push(4'b0010); exp_push(4'b1000);
    wait_gnt(20, n); chk("rr_gap", n, ADV + 1);
    wait_gnt(20, n); chk("rr_gap", n, ADV + 1);
    req = 4'b0000;
    wait_ready(20);

    // Seed load outranks grant in the same cycle
    seed_load = 1'b1; seed = 16'h0001; req = 4'b0001;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seed_nogrant", rnd_valid, 0);
    chk("seed_rnd_hold", rnd, last_rnd);
    ml = step(16'h0001, WARM);
    exp_push(4'b0001);
    busy_window();
    wait_gnt(3, n); chk("seed_lat", n, 1);
    req = 4'b0000;
    wait_ready(20);

    // Zero seed falls back to the reset pattern
    seed_load = 1'b1; seed = 16'h0000; req = 4'b0100;
    @(negedge clk);
    seed_load = 1'b0;
    ml = step(16'hACE1, WARM);
    exp_push(4'b0100); exp_push(4'b0100);
    busy_window();
    wait_gnt(3, n);  chk("seed0_lat", n, 1);
    wait_gnt(20, n); chk("seed0_gap", n, ADV + 1);
    req = 4'b0000;

    // Reset mid-ADVANCE clears rr_ptr and rnd
    for (int k = 0; k < 2; k++) begin
      wait_ready(40);
      req = 4'b0010;
      exp_push(4'b0010);
      wait_gnt(3, n);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_gnt", gnt, 0);
      chk("rst2_rnd", rnd, 0);
      chk("rst2_busy", busy, 1);
      ml = step(16'hACE1, WARM);
      req = pats[k];
      exp_push(4'b0001);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (rnd_valid) break;
        chk("rnd_zero", rnd, 0);
      end
      chk("rst2_gnt_seen", rnd_valid, 1);
      req = 4'b0000;
    end

    repeat (12) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
